p10_prm_ctrl: RTL and testbench

Parameter access controller for the p10 driver's parameter table. It serialises read/write commands from the command parser against the parameter ROM (`p10_rom`, 1-cycle registered read) and holds the live parameter values. Every write is checked against the ROM entry's access rights and min/max range before it is committed. Writes to exec-type parameters produce a one-cycle strobe instead of storing a value. After reset it walks the ROM and loads every parameter with its `min`.

---
 rtl/p10_prm_ctrl_pkg.sv | 43 ++++
 rtl/p10_prm_ctrl_if.sv | 29 ++
 rtl/p10_prm_check.sv | 26 ++
 rtl/p10_prm_ctrl.sv | 154 +++++++++++++++
 tb/tb_p10_prm_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/p10_prm_ctrl_pkg.sv
// Shared types for the p10 parameter controller: ROM entry layout, access rights,
// response status codes and the controller state encoding.
package p10_prm_ctrl_pkg;

    localparam int PRM_COUNT_DEF = 8;
    localparam int ADDR_FREQ     = 0;
    localparam int ADDR_DUTY     = 1;
    localparam int ADDR_PHASE    = 2;

    typedef enum logic [1:0] {
        ro = 2'd0,
        wo = 2'd1,
        rw = 2'd2
    } prm_rights_t;

    typedef struct packed {
        logic [31:0] min;
        logic [31:0] max;
        prm_rights_t rights;
        logic        is_exec;
    } prm_entry_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_BAD_ADDR = 2'd1,
        ST_DENIED   = 2'd2,
        ST_RANGE    = 2'd3
    } prm_status_t;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_FETCH = 3'd2,
        S_CHECK = 3'd3,
        S_RESP  = 3'd4
    } prm_state_t;

    // Bounds are inclusive on both ends and compared as unsigned values.
    function automatic logic in_range(input logic [31:0] data, input prm_entry_t entry);
        return (data >= entry.min) && (data <= entry.max);
    endfunction

endpackage

// File: rtl/p10_prm_ctrl_if.sv
// Command/response channel between the command parser (master) and the
// parameter controller (slave).
interface p10_prm_ctrl_if
    import p10_prm_ctrl_pkg::*;
#(
    parameter int AW = 4
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    prm_status_t   rsp_status;
    logic [31:0]   rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_data
    );

endinterface

// File: rtl/p10_prm_check.sv
// Access-rights and range check of one command against its ROM entry.
// Purely combinational; the exec flag is only raised for an otherwise valid write.
module p10_prm_check
    import p10_prm_ctrl_pkg::*;
(
    input  prm_entry_t  entry,
    input  logic        write,
    input  logic [31:0] data,
    output prm_status_t status,
    output logic        exec
);

    // Priority: rights violation first, then range, then the exec/store decision.
    always_comb begin
        status = ST_OK;
        exec   = 1'b0;
        if ((!write && entry.rights == wo) || (write && entry.rights == ro)) begin
            status = ST_DENIED;
        end else if (write && !in_range(data, entry)) begin
            status = ST_RANGE;
        end else if (write && entry.is_exec) begin
            exec = 1'b1;
        end
    end

endmodule

// File: rtl/p10_prm_ctrl.sv
// Parameter access controller: loads ROM minimums after reset, then serialises
// checked reads/writes of the live parameter table against the registered-read ROM.
module p10_prm_ctrl
    import p10_prm_ctrl_pkg::*;
#(
    parameter int PRM_COUNT = PRM_COUNT_DEF,
    parameter int AW        = $clog2(PRM_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    p10_prm_ctrl_if.slave              cmd_if,
    output logic [AW-1:0]              rom_addr,
    input  prm_entry_t                 rom_entry,
    output logic [PRM_COUNT-1:0][31:0] prm_val,
    output logic                       exec_stb,
    output logic [AW-1:0]              exec_addr,
    output logic [31:0]                exec_data
);

    localparam int IW = (PRM_COUNT > 1) ? $clog2(PRM_COUNT) : 1;

    prm_state_t                 state_q;
    logic [AW-1:0]              init_idx_q;
    logic [AW-1:0]              addr_q;
    logic                       write_q;
    logic [31:0]                data_q;
    logic                       cmd_ready_q;
    logic                       rsp_valid_q;
    prm_status_t                rsp_status_q;
    logic [31:0]                rsp_data_q;
    logic [PRM_COUNT-1:0][31:0] prm_val_q;
    logic                       exec_stb_q;
    logic [AW-1:0]              exec_addr_q;
    logic [31:0]                exec_data_q;

    logic [IW-1:0]              init_prev;
    logic                       init_last;
    logic                       cmd_addr_bad;
    prm_status_t                chk_status;
    logic                       chk_exec;

    // The ROM answers one cycle late, so init stores the entry addressed last cycle.
    assign init_prev    = IW'(init_idx_q - AW'(1));
    assign init_last    = (init_idx_q == AW'(PRM_COUNT));
    assign cmd_addr_bad = (cmd_if.cmd_addr >= AW'(PRM_COUNT));

    p10_prm_check u_check (
        .entry  (rom_entry),
        .write  (write_q),
        .data   (data_q),
        .status (chk_status),
        .exec   (chk_exec)
    );

    always_comb begin
        rom_addr = '0;
        case (state_q)
            S_INIT:  rom_addr = init_last ? AW'(PRM_COUNT - 1) : init_idx_q;
            S_FETCH: rom_addr = addr_q;
            default: rom_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_idx_q   <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            data_q       <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= '0;
            prm_val_q    <= '0;
            exec_stb_q   <= 1'b0;
            exec_addr_q  <= '0;
            exec_data_q  <= '0;
        end else begin
            exec_stb_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (init_idx_q != '0) begin
                        prm_val_q[init_prev] <= rom_entry.min;
                    end
                    if (init_last) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        init_idx_q <= init_idx_q + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        addr_q      <= cmd_if.cmd_addr;
                        write_q     <= cmd_if.cmd_write;
                        data_q      <= cmd_if.cmd_data;
                        cmd_ready_q <= 1'b0;
                        if (cmd_addr_bad) begin
                            state_q      <= S_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= ST_BAD_ADDR;
                            rsp_data_q   <= '0;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    state_q      <= S_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_status_q <= chk_status;
                    if (chk_status != ST_OK) begin
                        rsp_data_q <= '0;
                    end else if (!write_q) begin
                        rsp_data_q <= prm_val_q[addr_q[IW-1:0]];
                    end else begin
                        rsp_data_q <= data_q;
                        if (chk_exec) begin
                            exec_stb_q  <= 1'b1;
                            exec_addr_q <= addr_q;
                            exec_data_q <= data_q;
                        end else begin
                            prm_val_q[addr_q[IW-1:0]] <= data_q;
                        end
                    end
                end
                S_RESP: begin
                    if (cmd_if.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready  = cmd_ready_q;
    assign cmd_if.rsp_valid  = rsp_valid_q;
    assign cmd_if.rsp_status = rsp_status_q;
    assign cmd_if.rsp_data   = rsp_data_q;
    assign prm_val           = prm_val_q;
    assign exec_stb          = exec_stb_q;
    assign exec_addr         = exec_addr_q;
    assign exec_data         = exec_data_q;

endmodule

// File: tb/tb_p10_prm_ctrl.sv
// Directed bench for p10_prm_ctrl with a registered-read ROM model and a
// response scoreboard fed from a reference model of the parameter table.
module tb_p10_prm_ctrl;
    import p10_prm_ctrl_pkg::*;

    localparam int N  = 8;
    localparam int AW = 4;

    typedef struct {
        prm_status_t status;
        logic [31:0] data;
        logic        exec;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [AW-1:0]       rom_addr;
    prm_entry_t          rom_entry;
    logic [N-1:0][31:0]  prm_val;
    logic                exec_stb;
    logic [AW-1:0]       exec_addr;
    logic [31:0]         exec_data;

    prm_entry_t          rom_tbl [N];
    logic [31:0]         model_val [N];
    exp_t                exp_q [$];
    int                  n_checks = 0;
    int                  n_fail   = 0;

    p10_prm_ctrl_if #(.AW(AW)) cmd_if ();

    p10_prm_ctrl #(.PRM_COUNT(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_if    (cmd_if),
        .rom_addr  (rom_addr),
        .rom_entry (rom_entry),
        .prm_val   (prm_val),
        .exec_stb  (exec_stb),
        .exec_addr (exec_addr),
        .exec_data (exec_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle registered ROM read, zero for out-of-range addresses.
    always @(posedge clk) begin
        if (rom_addr < AW'(N)) rom_entry <= rom_tbl[rom_addr[2:0]];
        else                   rom_entry <= '0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < N; i++) model_val[i] = rom_tbl[i].min;
        exp_q.delete();
    endtask

    task automatic modelCmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data);
        exp_t       e;
        prm_entry_t r;
        e.status = ST_OK;
        e.data   = 32'd0;
        e.exec   = 1'b0;
        if (int'(addr) >= N) begin
            e.status = ST_BAD_ADDR;
        end else begin
            r = rom_tbl[addr[2:0]];
            if ((!wr && r.rights == wo) || (wr && r.rights == ro)) begin
                e.status = ST_DENIED;
            end else if (wr && (data < r.min || data > r.max)) begin
                e.status = ST_RANGE;
            end else if (wr) begin
                e.data = data;
                e.exec = r.is_exec;
                if (!r.is_exec) model_val[addr[2:0]] = data;
            end else begin
                e.data = model_val[addr[2:0]];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic checkPrmVals();
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("prm_val[%0d]", i), prm_val[i], model_val[i]);
        end
    endtask

    // Issues one command, follows it through latency, stall and handshake.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input int stall);
        int   n;
        exp_t e;
        logic bad;
        n = 0;
        while (!cmd_if.cmd_ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("cmd_ready_wait", 32'(cmd_if.cmd_ready), 32'd1);
        if (!cmd_if.cmd_ready) return;
        bad = (int'(addr) >= N);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_write = wr;
        cmd_if.cmd_addr  = addr;
        cmd_if.cmd_data  = data;
        cmd_if.rsp_ready = (stall == 0);
        modelCmd(wr, addr, data);
        tick();
        cmd_if.cmd_valid = 1'b0;
        checkOutput("cmd_ready_busy", 32'(cmd_if.cmd_ready), 32'd0);
        checkOutput("rom_addr_fetch", 32'(rom_addr), bad ? 32'd0 : 32'(addr));
        n = 1;
        while (!cmd_if.rsp_valid && n < 20) begin
            checkOutput("exec_early", 32'(exec_stb), 32'd0);
            tick();
            n++;
        end
        checkOutput("rsp_latency", 32'(n), bad ? 32'd1 : 32'd3);
        e = exp_q.pop_front();
        if (!cmd_if.rsp_valid) return;
        checkOutput("rsp_status", 32'(cmd_if.rsp_status), 32'(e.status));
        checkOutput("rsp_data", cmd_if.rsp_data, e.data);
        checkOutput("exec_stb", 32'(exec_stb), 32'(e.exec));
        if (e.exec) begin
            checkOutput("exec_addr", 32'(exec_addr), 32'(addr));
            checkOutput("exec_data", exec_data, data);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("stall_rsp_valid", 32'(cmd_if.rsp_valid), 32'd1);
            checkOutput("stall_rsp_status", 32'(cmd_if.rsp_status), 32'(e.status));
            checkOutput("stall_rsp_data", cmd_if.rsp_data, e.data);
            checkOutput("stall_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
            checkOutput("stall_exec_stb", 32'(exec_stb), 32'd0);
        end
        cmd_if.rsp_ready = 1'b1;
        tick();
        checkOutput("rsp_valid_drop", 32'(cmd_if.rsp_valid), 32'd0);
        checkOutput("cmd_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
        checkOutput("exec_stb_after", 32'(exec_stb), 32'd0);
        checkPrmVals();
    endtask

    initial begin
        int n;
        rom_tbl[0] = '{32'd0,  32'd500000,   rw, 1'b0};
        rom_tbl[1] = '{32'd0,  32'd50,       rw, 1'b0};
        rom_tbl[2] = '{32'd0,  32'd359,      rw, 1'b0};
        rom_tbl[3] = '{32'd5,  32'd100,      ro, 1'b0};
        rom_tbl[4] = '{32'd0,  32'd1000,     wo, 1'b0};
        rom_tbl[5] = '{32'd0,  32'd15,       rw, 1'b1};
        rom_tbl[6] = '{32'd10, 32'd20,       rw, 1'b0};
        rom_tbl[7] = '{32'd0,  32'hFFFFFFFF, rw, 1'b0};
        resetModel();
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_write = 1'b0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;
        cmd_if.rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("reset_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
        checkOutput("reset_rsp_status", 32'(cmd_if.rsp_status), 32'(ST_OK));
        checkOutput("reset_rsp_data", cmd_if.rsp_data, 32'd0);
        checkOutput("reset_exec_stb", 32'(exec_stb), 32'd0);
        checkOutput("reset_prm_duty", prm_val[ADDR_DUTY], 32'd0);
        rst = 1'b0;

        // Cycle k after release: rom_addr walks 0..7, cmd_ready rises in cycle 9.
        for (int k = 0; k <= 9; k++) begin
            if (k < N) checkOutput($sformatf("init_rom_addr_c%0d", k), 32'(rom_addr), 32'(k));
            checkOutput($sformatf("init_cmd_ready_c%0d", k), 32'(cmd_if.cmd_ready), (k == 9) ? 32'd1 : 32'd0);
            if (k < 9) tick();
        end
        checkPrmVals();

        applyStimulus(1'b1, AW'(ADDR_DUTY), 32'd25, 0);
        applyStimulus(1'b0, AW'(ADDR_DUTY), 32'd0, 0);
        applyStimulus(1'b1, AW'(ADDR_DUTY), 32'd51, 0);
        applyStimulus(1'b1, AW'(ADDR_FREQ), 32'd500000, 0);
        applyStimulus(1'b1, AW'(ADDR_FREQ), 32'd500001, 0);
        applyStimulus(1'b0, AW'(8), 32'd0, 0);
        applyStimulus(1'b1, AW'(15), 32'd3, 2);
        applyStimulus(1'b1, AW'(3), 32'd50, 0);
        applyStimulus(1'b0, AW'(3), 32'd0, 0);
        applyStimulus(1'b0, AW'(4), 32'd0, 0);
        applyStimulus(1'b1, AW'(4), 32'd123, 0);
        applyStimulus(1'b1, AW'(5), 32'd7, 5);
        applyStimulus(1'b1, AW'(5), 32'd16, 0);
        applyStimulus(1'b0, AW'(5), 32'd0, 0);
        applyStimulus(1'b1, AW'(6), 32'd9, 0);
        applyStimulus(1'b1, AW'(6), 32'd10, 0);
        applyStimulus(1'b1, AW'(6), 32'd20, 0);
        applyStimulus(1'b1, AW'(6), 32'd21, 0);
        applyStimulus(1'b1, AW'(7), 32'hFFFFFFFF, 3);
        applyStimulus(1'b0, AW'(7), 32'd0, 0);

        // Reset lands while the duty write sits in CHECK; the write must be lost.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_write = 1'b1;
        cmd_if.cmd_addr  = AW'(ADDR_DUTY);
        cmd_if.cmd_data  = 32'd10;
        cmd_if.rsp_ready = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
        checkOutput("midrst_exec_stb", 32'(exec_stb), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
        checkOutput("midrst_prm_duty", prm_val[ADDR_DUTY], 32'd0);
        rst = 1'b0;
        resetModel();
        n = 0;
        while (!cmd_if.cmd_ready && n < 30) begin
            tick();
            n++;
        end
        checkOutput("midrst_ready_cycles", 32'(n), 32'd9);
        checkPrmVals();

        applyStimulus(1'b0, AW'(ADDR_DUTY), 32'd0, 0);
        applyStimulus(1'b1, AW'(ADDR_PHASE), 32'd359, 0);
        applyStimulus(1'b0, AW'(ADDR_PHASE), 32'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
